// File: rtl/piano_key_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : piano_key_renderer
//  Description : Two-stage pixel generator for a two-octave keyboard drawn
//                along the bottom of a 1024x768 frame. Key state is sampled
//                once per frame at the start of vertical blanking and each
//                key stays lit for HOLD_FRAMES frames after release.
//  Revision    : 1.0 - initial release
// ============================================================================
module piano_key_renderer #(
  parameter logic [10:0] KB_TOP      = 11'd512,
  parameter logic [10:0] BLACK_H     = 11'd150,
  parameter logic [3:0]  HOLD_FRAMES = 4'd3
) (
  input  logic        clk_vga,
  input  logic        RST_N,
  input  logic [10:0] xpos,
  input  logic [10:0] ypos,
  input  logic [15:0] white_key,
  input  logic [10:0] black_key,
  output logic [11:0] rgb,
  output logic        rgb_valid
);

  localparam logic [10:0] c_BLACK_END = KB_TOP + BLACK_H;

  localparam logic [11:0] c_RGB_BLANK   = 12'h000;
  localparam logic [11:0] c_RGB_BG      = 12'h124;
  localparam logic [11:0] c_RGB_BLK_ON  = 12'hF80;
  localparam logic [11:0] c_RGB_BLK_OFF = 12'h000;
  localparam logic [11:0] c_RGB_SEP     = 12'h888;
  localparam logic [11:0] c_RGB_WHT_ON  = 12'h4AF;
  localparam logic [11:0] c_RGB_WHT_OFF = 12'hFFF;

  // A black key sits to the right of white keys C, D, F, G, A in each octave;
  // the last white key (w=15) closes the keyboard and has none.
  function automatic logic black_after(input logic [3:0] wi);
    case (wi)
      4'd0, 4'd1, 4'd3, 4'd4, 4'd5,
      4'd7, 4'd8, 4'd10, 4'd11, 4'd12,
      4'd14:   black_after = 1'b1;
      default: black_after = 1'b0;
    endcase
  endfunction

  // Number of black keys lying left of white key wi, i.e. the index of the
  // black key that follows wi when one exists.
  function automatic logic [3:0] black_index(input logic [3:0] wi);
    case (wi)
      4'd0:    black_index = 4'd0;
      4'd1:    black_index = 4'd1;
      4'd2:    black_index = 4'd2;
      4'd3:    black_index = 4'd2;
      4'd4:    black_index = 4'd3;
      4'd5:    black_index = 4'd4;
      4'd6:    black_index = 4'd5;
      4'd7:    black_index = 4'd5;
      4'd8:    black_index = 4'd6;
      4'd9:    black_index = 4'd7;
      4'd10:   black_index = 4'd7;
      4'd11:   black_index = 4'd8;
      4'd12:   black_index = 4'd9;
      4'd13:   black_index = 4'd10;
      4'd14:   black_index = 4'd10;
      default: black_index = 4'd11;
    endcase
  endfunction

  // ---------------------------------------------------------------- frame edge
  logic yact_q;
  logic vb_edge;

  // Remember whether the previous pixel was on an active line.
  always_ff @(posedge clk_vga or negedge RST_N) begin
    if (!RST_N) yact_q <= 1'b0;
    else        yact_q <= (ypos != 11'd0);
  end

  assign vb_edge = yact_q && (ypos == 11'd0);

  // ---------------------------------------------------------- hold counters
  logic [15:0] white_hl;
  logic [10:0] black_hl;

  for (genvar i = 0; i < 16; i++) begin : g_white
    logic [3:0] cnt_q;
    // Reload on a held key at frame start, otherwise count down to zero.
    always_ff @(posedge clk_vga or negedge RST_N) begin
      if (!RST_N) begin
        cnt_q <= 4'd0;
      end else if (vb_edge) begin
        if (white_key[i])        cnt_q <= HOLD_FRAMES;
        else if (cnt_q != 4'd0)  cnt_q <= cnt_q - 4'd1;
      end
    end
    assign white_hl[i] = (cnt_q != 4'd0);
  end

  for (genvar j = 0; j < 11; j++) begin : g_black
    logic [3:0] cnt_q;
    // Same hold behaviour for each black key.
    always_ff @(posedge clk_vga or negedge RST_N) begin
      if (!RST_N) begin
        cnt_q <= 4'd0;
      end else if (vb_edge) begin
        if (black_key[j])        cnt_q <= HOLD_FRAMES;
        else if (cnt_q != 4'd0)  cnt_q <= cnt_q - 4'd1;
      end
    end
    assign black_hl[j] = (cnt_q != 4'd0);
  end

  // ------------------------------------------------------------ stage 1
  logic [9:0] x0;
  logic [3:0] w_left;
  logic       hit_right;
  logic       hit_left;
  logic       act_d,     act_q;
  logic       bg_d,      bg_q;
  logic       blk_hit_d, blk_hit_q;
  logic [3:0] blk_idx_d, blk_idx_q;
  logic [3:0] w_d,       w_q;
  logic [5:0] off_d,     off_q;

  // Decode pixel position into white key, in-key offset and black-key hit.
  // xpos=1024 wraps x0[9:0] to 1023, which is exactly the last column.
  always_comb begin
    x0        = xpos[9:0] - 10'd1;
    w_d       = x0[9:6];
    off_d     = x0[5:0];
    w_left    = w_d - 4'd1;
    hit_right = (off_d >= 6'd44) && black_after(w_d);
    hit_left  = (off_d < 6'd20) && (w_d != 4'd0) && black_after(w_left);
    act_d     = (xpos != 11'd0) && (ypos != 11'd0);
    bg_d      = (ypos < KB_TOP);
    blk_hit_d = (ypos < c_BLACK_END) && (hit_right || hit_left);
    blk_idx_d = hit_right ? black_index(w_d) : black_index(w_left);
  end

  // Stage-1 pipeline register.
  always_ff @(posedge clk_vga or negedge RST_N) begin
    if (!RST_N) begin
      act_q     <= 1'b0;
      bg_q      <= 1'b0;
      blk_hit_q <= 1'b0;
      blk_idx_q <= 4'd0;
      w_q       <= 4'd0;
      off_q     <= 6'd0;
    end else begin
      act_q     <= act_d;
      bg_q      <= bg_d;
      blk_hit_q <= blk_hit_d;
      blk_idx_q <= blk_idx_d;
      w_q       <= w_d;
      off_q     <= off_d;
    end
  end

  // ------------------------------------------------------------ stage 2
  logic [15:0] black_hl_ext;
  logic [11:0] rgb_d, rgb_q;
  logic        valid_d, valid_q;

  assign black_hl_ext = {5'd0, black_hl};

  // Pick the colour by region priority: blank, background, black, separator, white.
  always_comb begin
    rgb_d   = c_RGB_BLANK;
    valid_d = act_q;
    if (!act_q) begin
      rgb_d = c_RGB_BLANK;
    end else if (bg_q) begin
      rgb_d = c_RGB_BG;
    end else if (blk_hit_q) begin
      rgb_d = black_hl_ext[blk_idx_q] ? c_RGB_BLK_ON : c_RGB_BLK_OFF;
    end else if (off_q == 6'd0) begin
      rgb_d = c_RGB_SEP;
    end else begin
      rgb_d = white_hl[w_q] ? c_RGB_WHT_ON : c_RGB_WHT_OFF;
    end
  end

  // Stage-2 output register.
  always_ff @(posedge clk_vga or negedge RST_N) begin
    if (!RST_N) begin
      rgb_q   <= 12'd0;
      valid_q <= 1'b0;
    end else begin
      rgb_q   <= rgb_d;
      valid_q <= valid_d;
    end
  end

  assign rgb       = rgb_q;
  assign rgb_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_piano_key_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_piano_key_renderer
//  Description : Self-checking bench for piano_key_renderer; randomized
//                pixels compared against a geometric keyboard model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_piano_key_renderer;

  localparam int KB_TOP  = 512;
  localparam int BLACK_H = 150;
  localparam int HOLD    = 3;

  logic        clk_vga = 1'b0;
  logic        RST_N   = 1'b0;
  logic [10:0] xpos    = '0;
  logic [10:0] ypos    = '0;
  logic [15:0] white_key = '0;
  logic [10:0] black_key = '0;
  logic [11:0] rgb;
  logic        rgb_valid;

  int checks   = 0;
  int failures = 0;

  piano_key_renderer dut (
    .clk_vga   (clk_vga),
    .RST_N     (RST_N),
    .xpos      (xpos),
    .ypos      (ypos),
    .white_key (white_key),
    .black_key (black_key),
    .rgb       (rgb),
    .rgb_valid (rgb_valid)
  );

  always #5 clk_vga = ~clk_vga;

  // ------------------------------------------------------------ model
  int          mw [16];
  int          mb [11];
  logic [10:0] prev_y = '0;
  logic [12:0] exp_q [$];

  function automatic bit blk_exists(int w);
    return (w < 15) && ((w % 7) inside {0, 1, 3, 4, 5});
  endfunction

  function automatic int blk_index(int w);
    int n = 0;
    for (int i = 0; i < w; i++) if (blk_exists(i)) n++;
    return n;
  endfunction

  // Expected {valid, rgb} for a pixel given the current hold state.
  function automatic logic [12:0] model_pixel(logic [10:0] x, logic [10:0] y);
    int x0, w, off, bi;
    bit bh;
    if (x == 0 || y == 0) return 13'h0000;
    if (int'(y) < KB_TOP) return {1'b1, 12'h124};
    x0 = int'(x) - 1; w = x0 / 64; off = x0 % 64; bh = 0; bi = 0;
    if (int'(y) < KB_TOP + BLACK_H) begin
      if (off >= 44 && blk_exists(w)) begin bh = 1; bi = blk_index(w); end
      else if (off < 20 && w > 0 && blk_exists(w - 1)) begin bh = 1; bi = blk_index(w - 1); end
    end
    if (bh) return {1'b1, (mb[bi] != 0) ? 12'hF80 : 12'h000};
    if (off == 0) return {1'b1, 12'h888};
    return {1'b1, (mw[w] != 0) ? 12'h4AF : 12'hFFF};
  endfunction

  function automatic logic [10:0] rnd(int lo, int hi);
    return 11'($urandom_range(hi, lo));
  endfunction

  // Drive one pixel; returns the DUT output now visible and the model's
  // expectation for the pixel driven two clocks earlier.
  task automatic step(input logic [10:0] x, input logic [10:0] y,
                      output logic [12:0] act, output logic [12:0] exp);
    @(negedge clk_vga);
    act = {rgb_valid, rgb};
    exp = exp_q.pop_front();
    xpos = x;
    ypos = y;
    exp_q.push_back(model_pixel(x, y));
    if (prev_y != 0 && y == 0) begin
      for (int i = 0; i < 16; i++) mw[i] = white_key[i] ? HOLD : (mw[i] > 0 ? mw[i] - 1 : 0);
      for (int j = 0; j < 11; j++) mb[j] = black_key[j] ? HOLD : (mb[j] > 0 ? mb[j] - 1 : 0);
    end
    prev_y = y;
  endtask

  task automatic reset_assert();
    @(negedge clk_vga);
    #2;
    RST_N = 1'b0;
    xpos  = '0;
    ypos  = '0;
  endtask

  task automatic reset_release();
    repeat (2) @(posedge clk_vga);
    @(negedge clk_vga);
    RST_N = 1'b1;
    for (int i = 0; i < 16; i++) mw[i] = 0;
    for (int j = 0; j < 11; j++) mb[j] = 0;
    exp_q.delete();
    exp_q.push_back(13'h0000);
    exp_q.push_back(13'h0000);
    prev_y = '0;
  endtask

  // ------------------------------------------------------------ tests
  task automatic test_reset();
    logic [12:0] a, e;
    repeat (2) @(posedge clk_vga);
    #1;
    checks++;
    if ({rgb_valid, rgb} !== 13'h0000) begin
      failures++;
      $display("FAIL reset_hold: got valid=%b rgb=%h, want valid=0 rgb=000", rgb_valid, rgb);
    end
    reset_release();
    for (int k = 0; k < 3; k++) begin
      step(11'd0, 11'd0, a, e);
      checks++;
      if (a !== 13'h0000) begin
        failures++;
        $display("FAIL reset_after: got valid=%b rgb=%h, want valid=0 rgb=000", a[12], a[11:0]);
      end
    end
  endtask

  task automatic test_idle_sweep();
    logic [12:0] a, e;
    logic [10:0] bx [11] = '{11'd1, 11'd1024, 11'd1024, 11'd1, 11'd65, 11'd1024, 11'd0, 11'd512, 11'd512, 11'd512, 11'd512};
    logic [10:0] by [11] = '{11'd1, 11'd768, 11'd600, 11'd512, 11'd600, 11'd0, 11'd768, 11'd511, 11'd512, 11'd661, 11'd662};
    for (int k = 0; k < 713; k++) begin
      logic [10:0] x, y;
      int r;
      r = int'($urandom_range(99, 0));
      if (k < 11)       begin x = bx[k]; y = by[k]; end
      else if (r < 7)   begin x = 11'd0; y = rnd(0, 768); end
      else if (r < 14)  begin x = rnd(0, 1024); y = 11'd0; end
      else if (r < 50)  begin x = rnd(1, 1024); y = rnd(1, 768); end
      else              begin x = rnd(1, 1024); y = rnd(KB_TOP, 768); end
      step(x, y, a, e);
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL idle_sweep k=%0d: got valid=%b rgb=%h, want valid=%b rgb=%h", k, a[12], a[11:0], e[12], e[11:0]);
      end
    end
  endtask

  task automatic test_latency();
    logic [12:0] a, e, want;
    step(11'd0, 11'd0, a, e);
    step(11'd0, 11'd0, a, e);
    for (int k = 0; k < 5; k++) begin
      if (k == 0) step(11'd100, 11'd600, a, e);
      else        step(11'd0, 11'd0, a, e);
      want = (k == 2) ? {1'b1, 12'hFFF} : 13'h0000;
      checks++;
      if (a !== want) begin
        failures++;
        $display("FAIL latency k=%0d: got valid=%b rgb=%h, want valid=%b rgb=%h", k, a[12], a[11:0], want[12], want[11:0]);
      end
    end
  endtask

  task automatic test_white_hold();
    logic [12:0] a, e, want;
    white_key = 16'h0002;
    for (int k = 0; k < 13; k++) begin
      step(rnd(1, 1024), (k < 10) ? rnd(1, 768) : 11'd0, a, e);
      checks++;
      if (a !== e) begin failures++; $display("FAIL hold_load k=%0d: got %h, want %h", k, a, e); end
    end
    white_key = 16'h0000;
    for (int f = 1; f <= 4; f++) begin
      for (int k = 0; k < 30; k++) begin
        step(rnd(60, 140), rnd(600, 768), a, e);
        checks++;
        if (a !== e) begin failures++; $display("FAIL hold_frame f=%0d: got %h, want %h", f, a, e); end
      end
      step(11'd100, 11'd700, a, e);
      step(11'd512, 11'd100, a, e);
      step(11'd512, 11'd100, a, e);
      want = {1'b1, (f <= 3) ? 12'h4AF : 12'hFFF};
      checks++;
      if (a !== want) begin
        failures++;
        $display("FAIL hold_probe f=%0d: got valid=%b rgb=%h, want valid=%b rgb=%h", f, a[12], a[11:0], want[12], want[11:0]);
      end
      for (int k = 0; k < 3; k++) step(11'd0, 11'd0, a, e);
    end
  endtask

  task automatic test_black_key0();
    logic [12:0] a, e;
    logic [10:0] px [5]   = '{11'd60, 11'd60, 11'd45, 11'd85, 11'd44};
    logic [10:0] py [5]   = '{11'd600, 11'd662, 11'd512, 11'd600, 11'd600};
    logic [11:0] pw [5]   = '{12'hF80, 12'hFFF, 12'hF80, 12'hFFF, 12'hFFF};
    black_key = 11'h001;
    for (int k = 0; k < 13; k++) step(rnd(1, 1024), (k < 10) ? rnd(1, 768) : 11'd0, a, e);
    black_key = 11'h000;
    for (int yi = 0; yi < 3; yi++) begin
      for (int x = 40; x <= 90; x++) begin
        step(11'(x), (yi == 0) ? 11'd512 : (yi == 1) ? 11'd661 : 11'd662, a, e);
        checks++;
        if (a !== e) begin failures++; $display("FAIL black0_map x=%0d: got %h, want %h", x, a, e); end
      end
    end
    for (int p = 0; p < 5; p++) begin
      step(px[p], py[p], a, e);
      step(11'd512, 11'd100, a, e);
      step(11'd512, 11'd100, a, e);
      checks++;
      if (a !== {1'b1, pw[p]}) begin
        failures++;
        $display("FAIL black0_probe x=%0d y=%0d: got valid=%b rgb=%h, want valid=1 rgb=%h", px[p], py[p], a[12], a[11:0], pw[p]);
      end
    end
    for (int k = 0; k < 3; k++) step(11'd0, 11'd0, a, e);
  endtask

  task automatic test_black_mapping();
    logic [12:0] a, e;
    logic [10:0] px [8] = '{11'd181, 11'd237, 11'd276, 11'd277, 11'd236, 11'd1024, 11'd1010, 11'd941};
    logic [11:0] pw [8] = '{12'hFFF, 12'hF80, 12'hF80, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'h000};
    black_key = 11'h004;
    for (int k = 0; k < 13; k++) step(rnd(1, 1024), (k < 10) ? rnd(1, 768) : 11'd0, a, e);
    black_key = 11'h000;
    for (int x = 160; x <= 290; x++) begin
      step(11'(x), 11'd600, a, e);
      checks++;
      if (a !== e) begin failures++; $display("FAIL black2_map x=%0d: got %h, want %h", x, a, e); end
    end
    for (int p = 0; p < 8; p++) begin
      step(px[p], 11'd600, a, e);
      step(11'd512, 11'd100, a, e);
      step(11'd512, 11'd100, a, e);
      checks++;
      if (a !== {1'b1, pw[p]}) begin
        failures++;
        $display("FAIL black2_probe x=%0d: got valid=%b rgb=%h, want valid=1 rgb=%h", px[p], a[12], a[11:0], pw[p]);
      end
    end
    for (int k = 0; k < 3; k++) step(11'd0, 11'd0, a, e);
  endtask

  task automatic test_midframe_toggle();
    logic [12:0] a, e;
    for (int k = 0; k < 33; k++) begin
      if (k == 10) white_key = 16'h0020;
      if (k == 20) white_key = 16'h0000;
      step(rnd(1, 1024), (k < 30) ? rnd(1, 768) : 11'd0, a, e);
      checks++;
      if (a !== e) begin failures++; $display("FAIL toggle_frame k=%0d: got %h, want %h", k, a, e); end
    end
    step(11'd351, 11'd700, a, e);
    step(11'd512, 11'd100, a, e);
    step(11'd512, 11'd100, a, e);
    checks++;
    if (a !== {1'b1, 12'hFFF}) begin
      failures++;
      $display("FAIL toggle_probe: got valid=%b rgb=%h, want valid=1 rgb=fff", a[12], a[11:0]);
    end
    for (int k = 0; k < 3; k++) step(11'd0, 11'd0, a, e);
  endtask

  task automatic test_vblank_hold();
    logic [12:0] a, e;
    white_key = 16'hFFFF;
    black_key = 11'h7FF;
    for (int k = 0; k < 25; k++) begin
      if (k == 20) begin white_key = '0; black_key = '0; end
      step(rnd(0, 1024), 11'd0, a, e);
      checks++;
      if (a !== e) begin failures++; $display("FAIL vblank_idle k=%0d: got %h, want %h", k, a, e); end
    end
    step(11'd351, 11'd700, a, e);
    step(11'd60, 11'd600, a, e);
    step(11'd512, 11'd100, a, e);
    checks++;
    if (a !== {1'b1, 12'hFFF}) begin failures++; $display("FAIL vblank_probe_white: got %h, want 1fff", a); end
    step(11'd512, 11'd100, a, e);
    checks++;
    if (a !== {1'b1, 12'h000}) begin failures++; $display("FAIL vblank_probe_black: got %h, want 1000", a); end
    for (int k = 0; k < 3; k++) step(11'd0, 11'd0, a, e);
  endtask

  task automatic test_reset_midframe();
    logic [12:0] a, e;
    white_key = 16'h0008;
    for (int k = 0; k < 13; k++) step(rnd(1, 1024), (k < 10) ? rnd(1, 768) : 11'd0, a, e);
    white_key = 16'h0080;
    for (int k = 0; k < 10; k++) step(rnd(1, 1024), rnd(1, 768), a, e);
    reset_assert();
    #1;
    checks++;
    if ({rgb_valid, rgb} !== 13'h0000) begin
      failures++;
      $display("FAIL reset_mid_async: got valid=%b rgb=%h, want valid=0 rgb=000", rgb_valid, rgb);
    end
    @(posedge clk_vga);
    #1;
    checks++;
    if ({rgb_valid, rgb} !== 13'h0000) begin
      failures++;
      $display("FAIL reset_mid_hold: got valid=%b rgb=%h, want valid=0 rgb=000", rgb_valid, rgb);
    end
    reset_release();
    step(11'd223, 11'd700, a, e);
    step(11'd479, 11'd700, a, e);
    step(11'd512, 11'd100, a, e);
    checks++;
    if (a !== {1'b1, 12'hFFF}) begin failures++; $display("FAIL reset_mid_w3: got %h, want 1fff", a); end
    step(11'd512, 11'd100, a, e);
    checks++;
    if (a !== {1'b1, 12'hFFF}) begin failures++; $display("FAIL reset_mid_w7_first: got %h, want 1fff", a); end
    for (int k = 0; k < 3; k++) step(11'd0, 11'd0, a, e);
    white_key = 16'h0000;
    for (int k = 0; k < 20; k++) begin
      step(rnd(1, 1024), rnd(KB_TOP, 768), a, e);
      checks++;
      if (a !== e) begin failures++; $display("FAIL reset_mid_frame k=%0d: got %h, want %h", k, a, e); end
    end
    step(11'd479, 11'd700, a, e);
    step(11'd512, 11'd100, a, e);
    step(11'd512, 11'd100, a, e);
    checks++;
    if (a !== {1'b1, 12'h4AF}) begin failures++; $display("FAIL reset_mid_w7_loaded: got %h, want 14af", a); end
    for (int k = 0; k < 3; k++) step(11'd0, 11'd0, a, e);
  endtask

  initial begin
    test_reset();
    test_idle_sweep();
    test_latency();
    test_white_hold();
    test_black_key0();
    test_black_mapping();
    test_midframe_toggle();
    test_vblank_hold();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
